// File: rtl/fixed_to_float_seq.sv
// Iterative signed fixed-point to IEEE-754 single converter with START/BUSY/DONE handshake.
// Optional macro FIXED_TO_FLOAT_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fixed_to_float_seq #(
   parameter int P    = 32,
   parameter int FRAC = 26
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [P-1:0] fixed_in,
   output logic         busy,
   output logic         done,
   output logic [31:0]  float_out,
   output logic [4:0]   shifts
);

   // state | meaning
   // IDLE  | waiting for start, operand captured on start
   // NORM  | one left shift per clock until mag[31] is set
   // PACK  | assemble sign/exponent/mantissa, pulse done next cycle
   typedef enum logic [1:0] {S_IDLE, S_NORM, S_PACK} state_t;

   localparam logic [7:0] EXP_INIT = 8'(158 - FRAC);

   state_t       state_q, state_d;
   logic         sign_q;
   logic         zero_q;
   logic [31:0]  mag_q;
   logic [7:0]   exp_q;
   logic [4:0]   cnt_q;
   logic [31:0]  mag_in;
   logic [7:0]   pack_exp;
   logic [22:0]  pack_mant;

   // Two's-complement magnitude; 0x80000000 wraps back to itself, which is the correct unsigned value.
   assign mag_in = fixed_in[P-1] ? (~fixed_in + 32'd1) : fixed_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (mag_in == 32'd0) ? S_PACK : S_NORM;
         end
         S_NORM: begin
            busy = 1'b1;
            if (mag_q[31]) state_d = S_PACK;
         end
         S_PACK: begin
            busy    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
   logic        round_inc;
   logic [23:0] mant_sum;

   always_comb begin
      round_inc = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
      mant_sum  = {1'b0, mag_q[30:8]} + {23'd0, round_inc};
      pack_exp  = exp_q;
      pack_mant = mant_sum[22:0];
      if (mant_sum[23]) begin
         pack_mant = 23'd0;
         pack_exp  = exp_q + 8'd1;
      end
   end
`else
   always_comb begin
      pack_exp  = exp_q;
      pack_mant = mag_q[30:8];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q    <= 1'b0;
         zero_q    <= 1'b0;
         mag_q     <= 32'd0;
         exp_q     <= 8'd0;
         cnt_q     <= 5'd0;
         done      <= 1'b0;
         float_out <= 32'd0;
         shifts    <= 5'd0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sign_q <= fixed_in[P-1];
                  mag_q  <= mag_in;
                  zero_q <= (mag_in == 32'd0);
                  exp_q  <= EXP_INIT;
                  cnt_q  <= 5'd0;
               end
            end
            S_NORM: begin
               if (!mag_q[31]) begin
                  mag_q <= {mag_q[30:0], 1'b0};
                  exp_q <= exp_q - 8'd1;
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            S_PACK: begin
               float_out <= zero_q ? 32'd0 : {sign_q, pack_exp, pack_mant};
               shifts    <= cnt_q;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Directed testbench for fixed_to_float_seq (FRAC=26) with hand-computed expected results.
module tb_fixed_to_float_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] fixed_in;
   logic        busy;
   logic        done;
   logic [31:0] float_out;
   logic [4:0]  shifts;

   int n_cmp = 0;
   int n_err = 0;

   fixed_to_float_seq #(.P(32), .FRAC(26)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .fixed_in  (fixed_in),
      .busy      (busy),
      .done      (done),
      .float_out (float_out),
      .shifts    (shifts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Waits for done after the capture edge; n counts edges with the capture edge as 1.
   task automatic wait_done(output int n, output bit seen);
      n    = 1;
      seen = done;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = done;
      end
   endtask

   task automatic convert(input string name, input logic [31:0] val, input logic [31:0] exp_f,
                          input logic [4:0] exp_s, input int exp_lat);
      int  n;
      bit  seen;
      @(negedge clk);
      fixed_in = val;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, " busy"}, {31'd0, busy}, 32'd1);
      wait_done(n, seen);
      chk({name, " done_seen"}, {31'd0, seen}, 32'd1);
      chk({name, " latency"}, n, exp_lat);
      chk({name, " float_out"}, float_out, exp_f);
      chk({name, " shifts"}, {27'd0, shifts}, {27'd0, exp_s});
      @(posedge clk); #1;
      chk({name, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({name, " idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      fixed_in = 32'd0;
      #23;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst float_out", float_out, 32'd0);
      chk("rst shifts", {27'd0, shifts}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic test_basic();
      convert("one",      32'h0400_0000, 32'h3F80_0000, 5'd5, 8);
      convert("neg_1p5",  32'hFA00_0000, 32'hBFC0_0000, 5'd5, 8);
      convert("three",    32'h0C00_0000, 32'h4040_0000, 5'd4, 7);
      convert("small",    32'h0000_0040, 32'h3580_0000, 5'd25, 28);
   endtask

   task automatic test_extremes();
      convert("zero",     32'h0000_0000, 32'h0000_0000, 5'd0, 2);
      convert("most_neg", 32'h8000_0000, 32'hC200_0000, 5'd0, 3);
      convert("lsb",      32'h0000_0001, 32'h3280_0000, 5'd31, 34);
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
      convert("most_pos", 32'h7FFF_FFFF, 32'h4200_0000, 5'd1, 4);
`else
      convert("most_pos", 32'h7FFF_FFFF, 32'h41FF_FFFF, 5'd1, 4);
`endif
   endtask

   task automatic test_back_to_back();
      int n;
      bit seen;
      @(negedge clk);
      fixed_in = 32'h0400_0000;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n, seen);
      chk("b2b first float_out", float_out, 32'h3F80_0000);
      fixed_in = 32'hFA00_0000;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b second busy", {31'd0, busy}, 32'd1);
      wait_done(n, seen);
      chk("b2b second latency", n, 8);
      chk("b2b second float_out", float_out, 32'hBFC0_0000);
   endtask

   task automatic test_busy_ignore_and_reset();
      int n;
      int pulses;
      bit seen;
      @(negedge clk);
      fixed_in = 32'h0400_0000;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      fixed_in = 32'h0000_0001;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 4;
      seen = done;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = done;
      end
      chk("ignore latency", n, 8);
      chk("ignore float_out", float_out, 32'h3F80_0000);
      chk("ignore shifts", {27'd0, shifts}, 32'd5);
      count_done(40, pulses);
      chk("ignore no_queue", pulses, 0);

      @(negedge clk);
      fixed_in = 32'h0000_0001;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort float_out", float_out, 32'd0);
      chk("abort shifts", {27'd0, shifts}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      count_done(40, pulses);
      chk("abort no_done", pulses, 0);
      convert("after_abort", 32'hFA00_0000, 32'hBFC0_0000, 5'd5, 8);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_busy_ignore_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
